// File: rtl/imm_extractor.sv
// imm_extractor -- registered immediate-operand extractor.
//
// Takes a stream of DW-bit instruction words and produces an IW-bit immediate.
// Each opcode word carries an FW-bit short field in its low bits and an opcode
// in the remaining high bits. The immediate is formed in one of three ways:
//   mode 00 : short field, zero-extended          (latency 1)
//   mode 01 : short field, sign-extended          (latency 1)
//   mode 10 : long immediate made of K = IW/DW extension words that follow
//             the opcode word, little-endian, gaps allowed
//   mode 11 : reserved; handled as mode 00 and flagged with o_err
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_instruccion  opcode or extension word
//   i_valid        i_instruccion (and i_mode with an opcode word) valid
//   i_mode         immediate mode, sampled with the opcode word only
//   i_flush        synchronous abort; drops the word presented with it
//   o_num          assembled immediate, held until the next o_valid
//   o_opcode       opcode bits of the last accepted opcode word
//   o_valid        one-cycle pulse when o_num/o_opcode are updated
//   o_busy         high while collecting extension words
//   o_err          one-cycle pulse with o_valid for the reserved mode
module imm_extractor #(
  parameter int DW = 8,
  parameter int FW = 3,
  parameter int IW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DW-1:0]    i_instruccion,
  input  logic             i_valid,
  input  logic [1:0]       i_mode,
  input  logic             i_flush,
  output logic [IW-1:0]    o_num,
  output logic [DW-FW-1:0] o_opcode,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_err
);

  localparam int K  = IW / DW;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       asm_q, asm_d;
  logic [IW-1:0]       num_q, num_d;
  logic [DW-FW-1:0]    opcode_q, opcode_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [IW-1:0]       asm_ins;
  logic [IW-1:0]       zext;
  logic [IW-1:0]       sext;

  // Assembly register with the current word dropped into the lane selected
  // by the word counter; all other lanes keep what has been collected so far.
  for (genvar gi = 0; gi < K; gi++) begin : g_lane
    assign asm_ins[gi*DW +: DW] = (cnt_q == CW'(gi)) ? i_instruccion
                                                     : asm_q[gi*DW +: DW];
  end

  assign zext = {{(IW-FW){1'b0}}, i_instruccion[FW-1:0]};
  assign sext = {{(IW-FW){i_instruccion[FW-1]}}, i_instruccion[FW-1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    num_d    = num_q;
    opcode_d = opcode_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (i_flush) begin
      // Flush beats i_valid: the word is dropped, partial data discarded,
      // and the visible outputs keep their last values.
      state_d = IDLE;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (i_valid) begin
      unique case (state_q)
        IDLE: begin
          opcode_d = i_instruccion[DW-1:FW];
          unique case (i_mode)
            2'b01: begin
              num_d   = sext;
              valid_d = 1'b1;
            end
            2'b10: begin
              state_d = COLLECT;
              cnt_d   = '0;
              asm_d   = '0;
            end
            default: begin
              num_d   = zext;
              valid_d = 1'b1;
              err_d   = (i_mode == 2'b11);
            end
          endcase
        end
        COLLECT: begin
          if (cnt_q == CW'(K-1)) begin
            num_d   = asm_ins;
            valid_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            asm_d   = '0;
          end else begin
            asm_d = asm_ins;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      asm_q    <= '0;
      num_q    <= '0;
      opcode_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      num_q    <= num_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign o_num    = num_q;
  assign o_opcode = opcode_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_err    = err_q;

endmodule
